dvi_video_timing: RTL and testbench
===================================

// Module: dvi_video_timing
// PURPOSE
//  Generates 640x480@60 video timing (hsync, vsync, de, pixel x/y) in the 25 MHz pixel-clock domain.
//  Clocked by the DVI PLL's pixel output; consumes the PLL lock flag. Timing is held idle until lock is stable.
//  Drives the downstream TMDS encoder/serializer and the framebuffer fetch logic.
// PARAMETERS
//  H_ACTIVE   640   visible pixels per line
//  H_FP       16    horizontal front porch, pixels
//  H_SYNC     96    hsync width, pixels
//  H_BP       48    horizontal back porch, pixels
//  V_ACTIVE   480   visible lines per frame
//  V_FP       10    vertical front porch, lines
//  V_SYNC     2     vsync width, lines
//  V_BP       33    vertical back porch, lines
//  HSYNC_POL  0     active level of hsync (0 = active-low)
//  VSYNC_POL  0     active level of vsync
//  LOCK_WAIT  1024  cycles of continuous synchronized lock required before timing starts (>=1)
// PORTS
//  clk          in   1   pixel clock, 25 MHz
//  reset_n      in   1   asynchronous active-low reset
//  pll_locked   in   1   PLL lock, asynchronous to clk
//  hsync        out  1   horizontal sync, polarity HSYNC_POL
//  vsync        out  1   vertical sync, polarity VSYNC_POL
//  de           out  1   data enable, high in active region
//  x            out  12  pixel column, valid when de
//  y            out  11  pixel row, valid when de
//  frame_start  out  1   1-cycle pulse coincident with de at (0,0)
//  line_start   out  1   1-cycle pulse coincident with de at x=0 of every active line
//  running      out  1   high while FSM is in RUN
// BEHAVIOUR
//  - Reset: hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, x=0, y=0, frame_start=0, line_start=0, running=0.
//    FSM=WAIT_LOCK, counters=0, synchronizer flops=0.
//  - pll_locked passes through a 2-flop synchronizer -> lock_s. No other logic samples pll_locked.
//  - FSM:
//    WAIT_LOCK: settle counter=0. When lock_s=1 -> SETTLE.
//    SETTLE: counter increments each cycle lock_s=1. lock_s=0 -> WAIT_LOCK.
//      Counter reaches LOCK_WAIT-1 -> RUN, h=0, v=0.
//    RUN: timing runs. lock_s=0 in any cycle -> WAIT_LOCK. Counters clear.
//      Outputs go to reset values on the next cycle.
//  - Counters, RUN only:
//    H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//    h increments each cycle. h wraps at H_TOTAL-1 -> 0 and v increments.
//    v wraps at V_TOTAL-1 -> 0 on the same cycle h wraps.
//  - Decode, all outputs registered, 1-cycle latency from (h,v):
//    de = (h<H_ACTIVE) && (v<V_ACTIVE).
//    hsync active iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
//    vsync active iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. vsync changes only with the line counter.
//    x=h, y=v when de. When de=0, x/y hold their last active values.
//    frame_start = (h==0 && v==0). line_start = (h==0 && v<V_ACTIVE).
//  - running is registered, aligned with the outputs: high from the first decoded RUN cycle.
//  - Widths: h is 12 bits, v is 11 bits. Totals are compile-time constants and must fit these widths.
//    No overflow is possible.
//  - Reset mid-frame: asynchronous return to reset values. Restart requires the full lock/settle sequence.
// STRUCTURE
//  - Package video_timing_pkg:
//    - 640x480@60 parameter defaults.
//    - H_TOTAL/V_TOTAL derivation functions.
//    - FSM state typedef: WAIT_LOCK, SETTLE, RUN.
//  - Sub-module sync_2ff (1-bit, async active-low reset to 0) for pll_locked.
//  - Remainder of the block: one FSM, two counters, one registered decode stage.
// TESTING
//  1. reset_n=0, pll_locked=1 -> all outputs at reset values.
//     hsync=1 and vsync=1 with default polarity. running=0.
//  2. Release reset, pll_locked held 1 from cycle 0, LOCK_WAIT=1024 ->
//     first de=1 and frame_start=1 exactly 1027 cycles after the first sampling edge. x=0, y=0 there.
//  3. Free run 2 frames -> per frame:
//     - de high for 307200 cycles, in 480 runs of 640.
//     - hsync low 96 cycles starting 656 after line_start.
//     - vsync low 1600 cycles (2 lines).
//     - frame_start period 420000.
//  4. Drop pll_locked for 1 cycle during SETTLE ->
//     FSM returns to WAIT_LOCK and the full LOCK_WAIT count restarts. No de pulse is emitted early.
//  5. Drop pll_locked mid-frame (v=200) ->
//     running=0 and de=0 within 4 cycles, hsync/vsync inactive.
//     On relock, resumes at frame_start with (0,0).
//  6. Assert reset_n low mid-line, asynchronously ->
//     outputs return to reset values without waiting for a clk edge.
//     Counters restart from 0 after release plus the settle sequence.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared defaults and helpers for the DVI video timing generator.
//   - 640x480@60 parameter defaults (pixels/lines)
//   - h_total / v_total derivation functions
//   - counter widths and the lock/settle/run FSM state type
package video_timing_pkg;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_LOCK_WAIT = 1024;

  localparam int H_W = 12;
  localparam int V_W = 11;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/dvi_video_timing_sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous level signal.
//   Ports:
//     clk   in  destination clock
//     rst_n in  asynchronous active-low reset, clears both flops to 0
//     d     in  asynchronous input
//     q     out synchronized output (2-cycle latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dvi_video_timing.sv
// dvi_video_timing
//   Video timing generator (default 640x480@60) in the pixel-clock domain.
//   Waits for a stable PLL lock, then runs horizontal/vertical counters and
//   decodes them into registered sync/enable/coordinate outputs.
//   Ports:
//     clk         in   pixel clock
//     reset_n     in   asynchronous active-low reset
//     pll_locked  in   PLL lock, asynchronous to clk
//     hsync       out  horizontal sync, active level HSYNC_POL
//     vsync       out  vertical sync, active level VSYNC_POL
//     de          out  data enable, high in active region
//     x, y        out  pixel column/row, valid when de (hold otherwise)
//     frame_start out  pulse with de at (0,0)
//     line_start  out  pulse with de at x=0 of every active line
//     running     out  high while timing is being decoded
module dvi_video_timing
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int LOCK_WAIT = DEF_LOCK_WAIT
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           pll_locked,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic           frame_start,
  output logic           line_start,
  output logic           running
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int CW      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(LOCK_WAIT - 1);

  logic           lock_s;
  state_t         state;
  logic [CW-1:0]  settle_cnt;
  logic [H_W-1:0] h;
  logic [V_W-1:0] v;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Lock qualification and raster counters. Any loss of lock drops straight
  // back to WAIT_LOCK so a relock always pays the full settle time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      h          <= '0;
      v          <= '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          settle_cnt <= '0;
          h          <= '0;
          v          <= '0;
          if (lock_s) state <= SETTLE;
        end
        SETTLE: begin
          if (!lock_s) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state      <= RUN;
            settle_cnt <= '0;
            h          <= '0;
            v          <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            h     <= '0;
            v     <= '0;
          end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
          end else begin
            h <= h + 1'b1;
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end

  // Decode stage: only cycles that the counter block treats as RUN are
  // decoded; the cycle lock is seen low already returns outputs to idle.
  logic live, de_c, hs_act, vs_act;

  always_comb begin
    live   = (state == RUN) && lock_s;
    de_c   = (h < H_ACT) && (v < V_ACT);
    hs_act = (h >= HS_BEG) && (h < HS_END);
    vs_act = (v >= VS_BEG) && (v < VS_END);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      running     <= 1'b0;
    end else if (!live) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      running     <= 1'b0;
    end else begin
      hsync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      de          <= de_c;
      frame_start <= (h == '0) && (v == '0);
      line_start  <= (h == '0) && (v < V_ACT);
      running     <= 1'b1;
      if (de_c) begin
        x <= h;
        y <= v;
      end
    end
  end

endmodule

// File: tb/tb_dvi_video_timing.sv
// tb_dvi_video_timing
//   Reduced raster (25x11) with the full 1024-cycle lock wait. A cycle model
//   pushes expected outputs each clock; a negedge checker pops and compares.
//   Directed sections measure lock latency, frame statistics, lock loss and
//   asynchronous reset.
module tb_dvi_video_timing;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
  localparam int LW = 1024;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pll_locked = 1'b1;
  logic        hsync, vsync, de, frame_start, line_start, running;
  logic [11:0] x;
  logic [10:0] y;

  int errs = 0;
  int nchk = 0;

  dvi_video_timing #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .LOCK_WAIT(LW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .line_start(line_start), .running(running)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs from the number of consecutive synchronized-lock cycles.
  // Decoding starts once lock has been seen LW+2 cycles in a row.
  function automatic logic [28:0] model(input int st, input logic [11:0] px, input logic [10:0] py);
    int p, h, v;
    logic d, hs, vs;
    if (st < LW + 2) return {6'b000011, 12'd0, 11'd0};
    p  = st - (LW + 2);
    h  = p % HT;
    v  = (p / HT) % VT;
    d  = (h < HA) && (v < VA);
    hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
    vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
    return {1'b1, (h == 0) && (v == 0), (h == 0) && (v < VA), d, hs, vs,
            d ? 12'(h) : px, d ? 11'(v) : py};
  endfunction

  logic [28:0] exp_q[$];
  logic        m1 = 1'b0, m2 = 1'b0;
  int          streak = 0;
  logic [11:0] lx = '0;
  logic [10:0] ly = '0;
  logic [28:0] exp_v;
  logic [28:0] dut_v;

  assign dut_v = {running, frame_start, line_start, de, hsync, vsync, x, y};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m1     <= 1'b0;
      m2     <= 1'b0;
      streak <= 0;
      lx     <= '0;
      ly     <= '0;
      exp_q.delete();
    end else begin
      exp_v = model(m2 ? streak + 1 : 0, lx, ly);
      exp_q.push_back(exp_v);
      lx     <= exp_v[22:11];
      ly     <= exp_v[10:0];
      streak <= m2 ? streak + 1 : 0;
      m1     <= pll_locked;
      m2     <= m1;
    end
  end

  always @(negedge clk) begin
    if (reset_n && exp_q.size() > 0) chk("scoreboard", 32'(dut_v), 32'(exp_q.pop_front()));
  end

  // Counts edges from now until de is sampled high (bounded).
  task automatic wait_de(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (de) break;
    end
    if (!de) chk("de_timeout", 32'(n), 32'(limit + 1));
  endtask

  initial begin
    int n, de_cnt, runs, hs_low, vs_low, hs_off, c_ls, max_run, cur_run;
    logic pde, phs;

    // 1: reset values with lock asserted
    repeat (3) @(negedge clk);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_ls", line_start, 0);
    chk("rst_running", running, 0);

    // 2: lock held from release
    reset_n = 1'b1;
    wait_de(5000, n);
    chk("first_de_latency", 32'(n - 1), 1027);
    chk("first_fs", frame_start, 1);
    chk("first_x", x, 0);
    chk("first_y", y, 0);

    // 3: two frames of statistics, starting at the frame_start sample
    for (int f = 0; f < 2; f++) begin
      de_cnt = 0; runs = 0; hs_low = 0; vs_low = 0; hs_off = -1; c_ls = 0;
      max_run = 0; cur_run = 0; pde = 1'b0; phs = 1'b1;
      for (int c = 0; c < HT * VT; c++) begin
        if (de) begin
          de_cnt++;
          cur_run++;
          if (cur_run > max_run) max_run = cur_run;
          if (!pde) runs++;
        end else cur_run = 0;
        if (line_start) c_ls = c;
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
        if (phs && !hsync && hs_off < 0) hs_off = c - c_ls;
        pde = de;
        phs = hsync;
        @(negedge clk);
      end
      chk("frame_de_cycles", 32'(de_cnt), 32'(HA * VA));
      chk("frame_de_runs", 32'(runs), 32'(VA));
      chk("frame_de_runlen", 32'(max_run), 32'(HA));
      chk("frame_hs_low", 32'(hs_low), 32'(HS * VT));
      chk("frame_hs_offset", 32'(hs_off), 32'(HA + HFP));
      chk("frame_vs_low", 32'(vs_low), 32'(VS * HT));
      chk("frame_period", frame_start, 1);
    end

    // 4: one-cycle lock drop during SETTLE restarts the full wait
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk); reset_n = 1'b1;
    repeat (500) @(negedge clk);
    pll_locked = 1'b0;
    @(posedge clk);
    @(negedge clk); pll_locked = 1'b1;
    chk("settle_no_de", de, 0);
    wait_de(3000, n);
    chk("settle_restart", 32'(n), 1028);
    chk("settle_fs", frame_start, 1);

    // 5: lock loss mid-frame, then relock
    n = 0;
    while (!(de && y == 11'd3) && n < 2 * HT * VT) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached", 32'(y), 3);
    pll_locked = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (!running && !de) break;
    end
    chk("drop_latency_le4", 32'(n <= 4), 1);
    chk("drop_hsync", hsync, 1);
    chk("drop_vsync", vsync, 1);
    pll_locked = 1'b1;
    wait_de(3000, n);
    chk("relock_fs", frame_start, 1);
    chk("relock_x", x, 0);
    chk("relock_y", y, 0);

    // 6: asynchronous reset mid-line
    n = 0;
    while (!(de && x == 12'd5) && n < 2 * HT * VT) begin
      @(negedge clk);
      n++;
    end
    chk("line_reached", 32'(x), 5);
    #5 reset_n = 1'b0;
    #1;
    chk("async_running", running, 0);
    chk("async_de", de, 0);
    chk("async_hsync", hsync, 1);
    chk("async_vsync", vsync, 1);
    chk("async_x", x, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_de(5000, n);
    chk("restart_latency", 32'(n - 1), 1027);
    chk("restart_fs", frame_start, 1);
    chk("restart_xy", {x, y}, 0);
    repeat (HT * 2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
